// File: rtl/riscv_dmem_sched_pkg.sv
// riscv_dmem_sched_pkg: access-size encodings, scheduler states and per-access tag type
package riscv_dmem_sched_pkg;
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef struct packed {
    logic we;
    logic discard;
  } ptag_t;
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lsb);
    return size == MEM_BYTE || (size == MEM_HALF && !lsb[0]) || (size == MEM_WORD && lsb == 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lsb);
    return size == MEM_WORD ? 4'hF : (size == MEM_HALF ? 4'b0011 : 4'b0001) << lsb;
  endfunction
endpackage

// File: rtl/riscv_dmem_sched_if.sv
// riscv_dmem_sched_if: data-bus request/grant plus in-order acknowledge channel
interface riscv_dmem_sched_if #(parameter int XLEN = 32);
  logic req, gnt, we, ack, err;
  logic [XLEN-1:0] adr, d, q;
  logic [XLEN/8-1:0] be;
  modport master(output req, adr, we, be, d, input gnt, ack, err, q);
  modport slave(input req, adr, we, be, d, output gnt, ack, err, q);
endinterface

// File: rtl/riscv_dmem_sched_ptag_fifo.sv
// riscv_dmem_sched_ptag_fifo: in-order {we, discard} tag queue, one entry per granted access
module riscv_dmem_sched_ptag_fifo
  import riscv_dmem_sched_pkg::*;
#(parameter int PENDING = 2) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  ptag_t din,
  output ptag_t head
);
  localparam int AW = PENDING > 1 ? $clog2(PENDING) : 1;
  ptag_t mem [PENDING];
  logic [AW-1:0] rd, wr;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(PENDING - 1) ? '0 : p + AW'(1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= nxt(wr);
      end
      if (pop) rd <= nxt(rd);
    end
  end
  assign head = mem[rd];
endmodule

// File: rtl/riscv_dmem_sched.sv
// riscv_dmem_sched: turns EX-stage loads/stores into data-bus transactions and generates the MEM stall
module riscv_dmem_sched
  import riscv_dmem_sched_pkg::*;
#(parameter int XLEN = 32, parameter int PENDING = 2) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_req,
  input  logic                      ex_bubble,
  input  logic                      ex_we,
  input  logic [1:0]                ex_size,
  input  logic [XLEN-1:0]           ex_adr,
  input  logic [XLEN-1:0]           ex_d,
  input  logic                      flush,
  riscv_dmem_sched_if.master        dmem,
  output logic                      mem_stall,
  output logic [XLEN-1:0]           mem_q,
  output logic                      mem_q_valid,
  output logic                      mem_misaligned,
  output logic                      mem_bus_err
);
  localparam int CW = $clog2(PENDING + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic load_pending, valid, aligned, capture, grant, ack, deliver, held_n, load_data;
  ptag_t head, tag;
  assign valid = ex_req && !ex_bubble && !flush;
  assign aligned = is_aligned(ex_size, ex_adr[1:0]);
  assign grant = dmem.req && dmem.gnt;
  assign ack = dmem.ack && cnt != '0;
  assign capture = valid && aligned && state != DRAIN && !dmem.req && cnt < CW'(PENDING) && !load_pending;
  // acks in DRAIN belong to squashed instructions; an ack coinciding with flush still counts
  assign deliver = ack && !head.discard && state != DRAIN;
  assign load_data = deliver && !head.we && !dmem.err;
  assign mem_stall = state != DRAIN && ((valid && aligned && !capture) || load_pending);
  assign held_n = capture || (dmem.req && !dmem.gnt);
  assign cnt_n = cnt + CW'(grant) - CW'(ack);
  assign tag = '{we: dmem.we, discard: flush || state == DRAIN};
  riscv_dmem_sched_ptag_fifo #(.PENDING(PENDING)) u_fifo (
    .clk, .rst, .push(grant), .pop(ack), .din(tag), .head
  );
  always_comb
    state_n = state == DRAIN ? (cnt == '0 && !dmem.req ? IDLE : DRAIN)
            : (flush && state == BUSY) ? DRAIN
            : (held_n || cnt_n != '0) ? BUSY : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      load_pending <= 1'b0;
      dmem.req <= 1'b0;
      dmem.adr <= '0;
      dmem.we <= 1'b0;
      dmem.be <= '0;
      dmem.d <= '0;
      mem_q <= '0;
      mem_q_valid <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_bus_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      load_pending <= (capture && !ex_we) || (load_pending && !(ack && !head.we));
      dmem.req <= held_n;
      if (capture) begin
        dmem.adr <= ex_adr;
        dmem.we <= ex_we;
        dmem.be <= byte_en(ex_size, ex_adr[1:0]);
        dmem.d <= ex_d;
      end
      if (load_data) mem_q <= dmem.q;
      mem_q_valid <= load_data;
      mem_misaligned <= valid && !aligned;
      mem_bus_err <= deliver && dmem.err;
    end
  end
  ack_needs_outstanding: assert property (@(posedge clk) disable iff (rst) !(dmem.ack && cnt == '0));
endmodule
